// File: rtl/sample_source_pkg.sv
// Shared types and default sizes for the sample playback source.
package sample_source_pkg;

  localparam int N     = 16;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int DIV_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/sample_source_if.sv
// Control, write-port and playback-output bundle of the sample source.
interface sample_source_if;
  import sample_source_pkg::*;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [N-1:0]     wr_data;
  logic             start;
  logic             stop;
  logic             loop_en;
  logic [AW-1:0]    last_addr;
  logic [DIV_W-1:0] rate_div;
  logic [N-1:0]     data_out;
  logic             sample_valid;
  logic             busy;
  logic             done;
  logic             wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop_en, last_addr, rate_div,
    input  data_out, sample_valid, busy, done, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop_en, last_addr, rate_div,
    output data_out, sample_valid, busy, done, wr_err
  );

endinterface

// File: rtl/sample_ram.sv
// DxW sample store: one synchronous write port, one registered read port, 1-cycle read latency.
// No backpressure; read-during-write to the same address returns the old word.
module sample_ram
  import sample_source_pkg::*;
#(
  parameter int W = N,
  parameter int D = DEPTH,
  parameter int A = AW
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [A-1:0] waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [A-1:0] raddr_i,
  output logic [W-1:0] rdata_o
);

  logic [W-1:0] mem [D];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sample_source.sv
// Plays stored samples at a programmable rate; first sample 2 cycles after start, then every rate_div+1.
// No backpressure: the consumer must take every sample_valid pulse; writes while playing are rejected.
module sample_source
  import sample_source_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  sample_source_if.slave  bus
);

  state_t           state_q;
  logic             loop_q;
  logic [AW-1:0]    last_q;
  logic [DIV_W-1:0] rate_q;
  logic [DIV_W-1:0] div_q;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    addr_d;
  logic [N-1:0]     data_q;
  logic             valid_q;
  logic             done_q;
  logic             wr_err_q;
  logic [N-1:0]     rdata;
  logic             tc;
  logic             at_last;
  logic             ram_we;

  // The RAM is addressed with the next address so its output already holds
  // the sample due at the next terminal count, even when rate_div is 0.
  always_comb begin
    tc      = (state_q == PLAY) && (div_q == rate_q);
    at_last = (addr_q == last_q);
    addr_d  = addr_q;
    if (state_q == IDLE || bus.stop) begin
      addr_d = '0;
    end else if (tc) begin
      addr_d = at_last ? '0 : addr_q + AW'(1);
    end
  end

  assign ram_we = bus.wr_en && (state_q == IDLE);

  sample_ram #(.W(N), .D(DEPTH), .A(AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i (addr_d),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      loop_q   <= 1'b0;
      last_q   <= '0;
      rate_q   <= '0;
      div_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= bus.wr_en && (state_q == PLAY);
      addr_q   <= addr_d;
      case (state_q)
        IDLE: begin
          data_q <= '0;
          if (bus.start) begin
            state_q <= PLAY;
            loop_q  <= bus.loop_en;
            last_q  <= bus.last_addr;
            rate_q  <= bus.rate_div;
            // Preloading the terminal count emits mem[0] on the first PLAY cycle.
            div_q   <= bus.rate_div;
          end
        end
        PLAY: begin
          if (bus.stop) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            data_q  <= '0;
            div_q   <= '0;
          end else if (tc) begin
            valid_q <= 1'b1;
            data_q  <= rdata;
            div_q   <= '0;
            if (at_last && !loop_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_out     = data_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = (state_q == PLAY);
  assign bus.done         = done_q;
  assign bus.wr_err       = wr_err_q;

endmodule
